// File: rtl/glitch_free_clk_div_switch.sv
// rtl/glitch_free_clk_div_switch.sv - divided clock generator with glitch-free run-time ratio switching
// Optional feature macro GFCD_STOP_EN: div_val=0 parks clkout low at a period boundary.
module glitch_free_clk_div_switch #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             clkout,
  output logic             clk_en
);

  localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef GFCD_STOP_EN
    ST_STOPPED,
`endif
    ST_PEND
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             clkout_q, clkout_d;
  logic             clk_en_q, clk_en_d;
  logic             div_ack_q, div_ack_d;
  logic             stopped;
  logic             boundary;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] half;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
`ifdef GFCD_STOP_EN
    if (v == '0) return '0;
`endif
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

`ifdef GFCD_STOP_EN
  assign stopped = (cur_div_q == '0);
`else
  assign stopped = 1'b0;
`endif

  // While stopped every edge counts as a boundary so a pending ratio applies at once.
  assign boundary = stopped | (cnt_q == cur_div_q - DIV_W'(1));
  assign cnt_nxt  = cnt_q + DIV_W'(1);
  assign half     = cur_div_q >> 1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    clkout_d   = 1'b0;
    clk_en_d   = 1'b0;
    div_ack_d  = 1'b0;

    if (state_q == ST_PEND && boundary) begin
      div_ack_d = 1'b1;
      cur_div_d = pend_div_q;
      cnt_d     = '0;
`ifdef GFCD_STOP_EN
      if (pend_div_q == '0) begin
        state_d = ST_STOPPED;
      end else
`endif
      begin
        state_d  = ST_IDLE;
        clkout_d = 1'b1;
        clk_en_d = 1'b1;
      end
    end else if (!stopped) begin
      if (boundary) begin
        cnt_d    = '0;
        clkout_d = 1'b1;
        clk_en_d = 1'b1;
      end else begin
        cnt_d    = cnt_nxt;
        clkout_d = (cnt_nxt < half);
      end
    end

    // Requests are evaluated after the boundary decision, so one sampled at a boundary waits a period.
    if (state_q != ST_PEND && div_req) begin
      state_d    = ST_PEND;
      pend_div_d = clamp_div(div_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= RST_DIV - DIV_W'(1);
      cur_div_q  <= RST_DIV;
      pend_div_q <= '0;
      clkout_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      div_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      clkout_q   <= clkout_d;
      clk_en_q   <= clk_en_d;
      div_ack_q  <= div_ack_d;
    end
  end

  assign div_ack = div_ack_q;
  assign busy    = (state_q == ST_PEND);
  assign cur_div = cur_div_q;
  assign clkout  = clkout_q;
  assign clk_en  = clk_en_q;

endmodule

// File: tb/tb_glitch_free_clk_div_switch.sv
// tb/tb_glitch_free_clk_div_switch.sv - bench for glitch_free_clk_div_switch with a period-queue reference model
module tb_glitch_free_clk_div_switch;
  localparam int DIV_W = 8;
  localparam int DEF   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             div_req = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_ack, busy, clkout, clk_en;
  logic [DIV_W-1:0] cur_div;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  glitch_free_clk_div_switch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .div_req(div_req), .div_val(div_val),
    .div_ack(div_ack), .busy(busy), .cur_div(cur_div), .clkout(clkout), .clk_en(clk_en)
  );

  // Reference model: each period is a queued waveform of H ones then N-H zeros; an empty queue is a boundary.
  int m_cur = DEF;
  int m_pend = 0;
  bit m_pv = 1'b0;
  bit m_stop = 1'b0;
  bit m_was;
  bit q_out[$];
  bit e_clk = 1'b0, e_en = 1'b0, e_ack = 1'b0;

  function automatic int clampv(int v);
`ifdef GFCD_STOP_EN
    if (v == 0) return 0;
`endif
    return (v < 2) ? 2 : v;
  endfunction

  task automatic start_period(int n);
    q_out.delete();
    for (int i = 0; i < n; i++) q_out.push_back(i < n / 2);
    e_clk = q_out.pop_front();
    e_en  = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cur = (DEF < 2) ? 2 : DEF;
      m_pv = 1'b0; m_stop = 1'b0; q_out.delete();
      e_clk = 1'b0; e_en = 1'b0; e_ack = 1'b0;
    end else begin
      m_was = m_pv;
      e_ack = 1'b0; e_en = 1'b0; e_clk = 1'b0;
      if (q_out.size() == 0) begin
        if (m_was) begin
          m_pv = 1'b0; e_ack = 1'b1; m_cur = m_pend;
          if (m_cur == 0) m_stop = 1'b1;
          else begin m_stop = 1'b0; start_period(m_cur); end
        end else if (!m_stop) begin
          start_period(m_cur);
        end
      end else begin
        e_clk = q_out.pop_front();
      end
      if (!m_was && div_req) begin
        m_pv = 1'b1; m_pend = clampv(int'(div_val));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({clkout, clk_en, div_ack, busy} !== {e_clk, e_en, e_ack, m_pv} || cur_div !== DIV_W'(m_cur)) begin
        fails++;
        $display("FAIL model t=%0t: got clkout=%b clk_en=%b ack=%b busy=%b cur_div=%0d, expected %b %b %b %b %0d",
                 $time, clkout, clk_en, div_ack, busy, cur_div, e_clk, e_en, e_ack, m_pv, m_cur);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic req, input logic [DIV_W-1:0] val);
    div_req = req;
    div_val = val;
    @(negedge clk);
  endtask

  task automatic req_wait(input logic [DIV_W-1:0] val, output int lat);
    step(1'b1, val);
    lat = 1;
    while (!div_ack && lat < 40) begin
      step(1'b0, '0);
      lat++;
    end
    chk("ack_seen", int'(div_ack), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat_clk;
    logic [7:0] pat_en;
    int lat;
    bit ack_seen;
    pat_clk = 8'b0011_0011;
    pat_en  = 8'b0001_0001;

    rst_n = 1'b0;
    step(1'b0, '0);
    chk_en = 1'b1;
    repeat (2) step(1'b0, '0);
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_div", int'(cur_div), 4);

    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      chk("n4_clkout", int'(clkout), int'(pat_clk[i]));
      chk("n4_clk_en", int'(clk_en), int'(pat_en[i]));
    end

    // Request sampled in the boundary cycle: ack comes N_old+1 cycles later; second request ignored.
    step(1'b1, 8'd2);
    lat = 1;
    chk("bnd_busy", int'(busy), 1);
    step(1'b1, 8'd7);
    lat++;
    while (!div_ack && lat < 20) begin
      step(1'b0, '0);
      lat++;
    end
    chk("bnd_latency", lat, 5);
    chk("bnd_ack_busy", int'(busy), 0);
    chk("bnd_ack_clkout", int'(clkout), 1);
    chk("bnd_ack_clk_en", int'(clk_en), 1);
    chk("bnd_cur_div", int'(cur_div), 2);
    step(1'b0, '0);
    chk("n2_low", int'(clkout), 0);
    step(1'b0, '0);
    chk("n2_high", int'(clkout), 1);
    chk("n2_no_extra_ack", int'(div_ack), 0);
    chk("n2_cur_div_kept", int'(cur_div), 2);

    // N=3 -> 5 switch requested at cnt=0.
    req_wait(8'd3, lat);
    chk("n3_cur_div", int'(cur_div), 3);
    step(1'b1, 8'd5);
    chk("n3to5_busy1", int'(busy), 1);
    chk("n3to5_low1", int'(clkout), 0);
    step(1'b0, '0);
    chk("n3to5_busy2", int'(busy), 1);
    chk("n3to5_low2", int'(clkout), 0);
    step(1'b0, '0);
    chk("n3to5_ack", int'(div_ack), 1);
    chk("n3to5_first_high", int'(clkout), 1);
    chk("n3to5_cur_div", int'(cur_div), 5);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0);
      chk("n5_pattern", int'(clkout), (i == 0) ? 1 : 0);
    end

    req_wait(8'd1, lat);
    chk("clamp1_cur_div", int'(cur_div), 2);
    step(1'b0, '0);
    chk("clamp1_low", int'(clkout), 0);
    step(1'b0, '0);
    chk("clamp1_high", int'(clkout), 1);
`ifndef GFCD_STOP_EN
    req_wait(8'd0, lat);
    chk("clamp0_cur_div", int'(cur_div), 2);
`endif

    // Reset while busy in the high phase discards the request.
    req_wait(8'd6, lat);
    step(1'b1, 8'd4);
    chk("rstbusy_busy", int'(busy), 1);
    chk("rstbusy_high", int'(clkout), 1);
    rst_n = 1'b0;
    step(1'b0, '0);
    chk("rstbusy_clkout", int'(clkout), 0);
    chk("rstbusy_busy0", int'(busy), 0);
    chk("rstbusy_cur_div", int'(cur_div), 4);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    repeat (20) begin
      step(1'b0, '0);
      ack_seen |= div_ack;
    end
    chk("rstbusy_no_ack", int'(ack_seen), 0);

`ifdef GFCD_STOP_EN
    req_wait(8'd0, lat);
    chk("stop_clkout", int'(clkout), 0);
    chk("stop_clk_en", int'(clk_en), 0);
    chk("stop_cur_div", int'(cur_div), 0);
    repeat (3) begin
      step(1'b0, '0);
      chk("stop_held", int'(clkout), 0);
    end
    step(1'b1, 8'd6);
    chk("restart_busy", int'(busy), 1);
    step(1'b0, '0);
    chk("restart_clkout", int'(clkout), 1);
    chk("restart_clk_en", int'(clk_en), 1);
    chk("restart_ack", int'(div_ack), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0);
      chk("n6_pattern", int'(clkout), (i < 2) ? 1 : 0);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      step($urandom_range(0, 5) == 0, DIV_W'($urandom_range(0, 9)));
    end
    rst_n = 1'b1;
    step(1'b0, '0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glitch_free_clk_div_switch.md
# glitch_free_clk_div_switch

Parametrised single-clock divided-clock generator whose division ratio can be changed at run time without producing runt high or low phases on the output. A ratio change is requested over a req/ack handshake and takes effect only at a period boundary, when `clkout` is low and the low phase has fully completed. It sits beside the glitch-free clock muxes in the clocking block and feeds slow peripheral clocks and their matching enable strobes.

## Interface
- `DIV_W`, 8: width of ratio fields.
- `DEFAULT_DIV`, 2: ratio loaded at reset. Values below 2 are clamped to 2.
- `clk` in 1: sole clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `div_req` in 1: ratio change request, sampled while `busy`=0.
- `div_val` in DIV_W: requested ratio, captured with `div_req`.
- `div_ack` out 1: one-cycle pulse in the cycle the new ratio takes effect.
- `busy` out 1: a request is latched and waiting for a boundary.
- `cur_div` out DIV_W: ratio currently in effect.
- `clkout` out 1: registered divided clock.
- `clk_en` out 1: one-cycle pulse coincident with each `clkout` rising edge.

## Operation
- Period counter `cnt` runs over 0..N-1, where N = `cur_div`.
- High phase H = floor(N/2) cycles. Low phase = N-H cycles, which is always at least 1.
- Per edge, at the boundary (`cnt`==N-1):
  - `cnt` goes to 0.
  - `clkout` goes to 1.
  - `clk_en` goes to 1.
- Per edge, otherwise:
  - `cnt` goes to `cnt`+1.
  - `clkout` goes to (`cnt`+1 < H).
  - `clk_en` goes to 0.
- Example waveforms: N=2 gives 1,0. N=3 gives 1,0,0. N=5 gives 1,1,0,0,0.
- Ratio clamp: requested values 0 and 1 become 2 (see Configuration for 0). Values ≥2 are used as-is, up to 2^DIV_W-1.
- States:
  - IDLE: `busy`=0.
  - PEND: `busy`=1, `pend_div` holds the latched ratio.
- IDLE→PEND on `div_req`=1. `div_val` is captured into `pend_div`.
- PEND→IDLE at the next boundary edge:
  - `cur_div` loads `pend_div`.
  - `cnt` goes to 0.
  - The new period starts high, with H computed from the new ratio.
  - `div_ack`=1 for that cycle.
- `div_req` while `busy`=1 is ignored. It produces no extra ack and does not overwrite `pend_div`.
- A request sampled in a boundary cycle is not applied at that boundary. It waits for the following one.
- A request equal to `cur_div` still goes through PEND and is acked at the next boundary.
- The old ratio's low phase always completes, so no high or low phase shorter than min(H_old, H_new) is ever emitted.

## Timing
- Reset values:
  - `cnt`=N-1, so the first edge after release is a boundary.
  - `clkout`=0, `clk_en`=0, `div_ack`=0, `busy`=0.
  - `cur_div`=clamped DEFAULT_DIV. Pending state is cleared.
- First edge after `rst_n` rises: `clkout`=1 and `clk_en`=1.
- `busy` rises the cycle after `div_req` is accepted.
- `div_ack`, `clk_en`, and the first high cycle of the new ratio appear in the same cycle. `busy` is 0 in that cycle.
- Request-to-ack latency: 1 to N_old cycles, or N_old+1 if the request is sampled in a boundary cycle.
- Reset asserted mid-period or mid-request: all outputs take reset values on the next edge. The pending request is discarded and no ack is issued.
- `clkout`, `clk_en` and `div_ack` are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- `GFCD_STOP_EN` defined:
  - `div_val`=0 requests a glitch-free stop. At the boundary, `cur_div`=0 and `div_ack` pulses.
  - Third state STOPPED is entered: `clkout` held 0, `clk_en` 0, `cnt` frozen.
  - In STOPPED, an accepted nonzero request is applied on the following edge (the boundary is immediate). That edge gives `clkout`=1, `clk_en`=1 and `div_ack`=1.
  - A request of 0 while STOPPED is acked on the next edge with no other effect.
  - `div_val`=1 still clamps to 2.
- `GFCD_STOP_EN` undefined: no STOPPED state, and 0 clamps to 2 like 1.

## Test plan
- Reset, DEFAULT_DIV=4: 3 cycles low, then release -> `clkout` 1,1,0,0 repeating, with `clk_en` on each first 1 and `cur_div`=4.
- N=3, `div_req` with `div_val`=5 at `cnt`=0 -> `busy` for 2 cycles, then `div_ack` with `clkout` pattern 1,0,0 followed by 1,1,0,0,0, and no short phases.
- Request sampled at a boundary cycle (N=4, `div_val`=2) -> ack exactly 5 cycles later. A second `div_req` (value 7) while busy is ignored and `cur_div` ends at 2.
- `div_val`=1 and (macro off) 0 -> `cur_div`=2 after ack, `clkout` 1,0 toggling.
- Reset asserted while busy, mid-high phase -> next edge `clkout`=0, `busy`=0, no `div_ack` ever for that request.
- With `GFCD_STOP_EN`: request 0 at N=4 -> full low phase, then `clkout` held 0 with ack. Request 6 -> the next edge gives `clkout`=1, `clk_en`=1 and `div_ack`=1, then the pattern 1,1,1,0,0,0.
